// File: rtl/seg7_display.sv
// -----------------------------------------------------------------------------
// seg7_display
// Shows an 8-bit unsigned value as a decimal number on a 4-digit multiplexed
// 7-segment display. An iterative double-dabble FSM converts the value to BCD
// whenever it changes. A prescaled scan counter time-multiplexes the digits.
//
// Ports
//   clk     in   1  system clock, all state on posedge
//   rst     in   1  asynchronous active-low reset
//   dataIn  in   8  unsigned value to display
//   an      out  4  digit enables, active-low one-hot; an[0]=ones .. an[3]=leftmost
//   seg     out  7  segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   dp      out  1  decimal point, always off
//   busy    out  1  high while a conversion is in progress
// -----------------------------------------------------------------------------
module seg7_display #(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] dataIn,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       busy
);

   localparam logic [16:0] PRESC_MAX = 17'(SCAN_DIV - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
   function automatic logic [11:0] bcd_add3(input logic [11:0] b);
      logic [11:0] r;
      for (int i = 0; i < 3; i++) begin
         r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? (b[i*4 +: 4] + 4'd3) : b[i*4 +: 4];
      end
      return r;
   endfunction

   // Active-high gfedcba pattern; codes above 9 cannot occur and show blank.
   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   state_e      state_q, state_d;
   logic [7:0]  last_q,  last_d;
   logic [7:0]  shift_q, shift_d;
   logic [11:0] bcd_q,   bcd_d;
   logic [2:0]  cnt_q,   cnt_d;
   logic [11:0] disp_q,  disp_d;
   logic [16:0] presc_q, presc_d;
   logic [1:0]  idx_q,   idx_d;
   logic [11:0] bcd_adj_s;
   logic [6:0]  pat_s;

   assign bcd_adj_s = bcd_add3(bcd_q);

   // State registers for the converter and the scan counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         last_q  <= 8'd0;
         shift_q <= 8'd0;
         bcd_q   <= 12'd0;
         cnt_q   <= 3'd0;
         disp_q  <= 12'd0;
         presc_q <= 17'd0;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
      end
   end

   // Conversion FSM next-state logic.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      shift_d = shift_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      case (state_q)
         ST_IDLE: begin
            // Comparing against the last converted value (not the display)
            // means a value that bounces back during busy starts nothing.
            if (dataIn != last_q) begin
               shift_d = dataIn;
               last_d  = dataIn;
               bcd_d   = 12'd0;
               cnt_d   = 3'd0;
               state_d = ST_CONV;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CONV: begin
            {bcd_d, shift_d} = {bcd_adj_s[10:0], shift_q, 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_CONV;
            end
         end
         ST_DONE: begin
            // Only here does the display change, so the scan never sees partial BCD.
            disp_d  = bcd_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Scan prescaler: each digit stays lit for SCAN_DIV cycles.
   always_comb begin
      presc_d = presc_q;
      idx_d   = idx_q;
      if (presc_q >= PRESC_MAX) begin
         presc_d = 17'd0;
         idx_d   = idx_q + 2'd1;
      end else begin
         presc_d = presc_q + 17'd1;
         idx_d   = idx_q;
      end
   end

   // Digit content with leading-zero blanking.
   always_comb begin
      pat_s = 7'h00;
      case (idx_q)
         2'd0: pat_s = seg_pattern(disp_q[3:0]);
         2'd1: begin
            if ((disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0)) begin
               pat_s = 7'h00;
            end else begin
               pat_s = seg_pattern(disp_q[7:4]);
            end
         end
         2'd2: begin
            if (disp_q[11:8] == 4'd0) begin
               pat_s = 7'h00;
            end else begin
               pat_s = seg_pattern(disp_q[11:8]);
            end
         end
         2'd3:    pat_s = 7'h00;
         default: pat_s = 7'h00;
      endcase
   end

   assign seg  = SEG_ACTIVE_LOW ? ~pat_s : pat_s;
   assign dp   = SEG_ACTIVE_LOW;
   assign an   = ~(4'b0001 << idx_q);
   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seg7_display.sv
// -----------------------------------------------------------------------------
// tb_seg7_display
// Directed self-checking bench for seg7_display with SCAN_DIV=4 and active-low
// segments. A cycle counter reset alongside the DUT predicts the scanned digit.
// -----------------------------------------------------------------------------
module tb_seg7_display;

   logic       clk;
   logic       rst;
   logic [7:0] dataIn;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int k        = 0;

   // Active-low digit patterns (gfedcba)
   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] SB = 7'b1111111;

   seg7_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clk    (clk),
      .rst    (rst),
      .dataIn (dataIn),
      .an     (an),
      .seg    (seg),
      .dp     (dp),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release: scan index = (k/4) mod 4
   always @(posedge clk or negedge rst) begin
      if (!rst) k <= 0;
      else      k <= k + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check the currently lit digit against the four expected patterns.
   task automatic check_now(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
      logic [1:0] idx;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      idx = 2'((k >> 2) & 3);
      case (idx)
         2'd0:    begin exp_an = 4'b1110; exp_seg = s0; end
         2'd1:    begin exp_an = 4'b1101; exp_seg = s1; end
         2'd2:    begin exp_an = 4'b1011; exp_seg = s2; end
         default: begin exp_an = 4'b0111; exp_seg = s3; end
      endcase
      chk({tag, "_an"},  32'(an),  32'(exp_an));
      chk({tag, "_seg"}, 32'(seg), 32'(exp_seg));
   endtask

   // One full scan (16 cycles) with the display stable and no conversion.
   task automatic check_scan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2);
      for (int i = 0; i < 16; i++) begin
         check_now(tag, s0, s1, s2, SB);
         chk({tag, "_busy"}, 32'(busy), 32'd0);
         chk({tag, "_dp"},   32'(dp),   32'd1);
         @(negedge clk);
      end
   endtask

   // Count negedges with busy high (bounded); returns at first negedge with busy low.
   task automatic busy_len(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   int n;

   initial begin
      // T1 reset
      rst    = 1'b0;
      dataIn = 8'd0;
      repeat (3) @(negedge clk);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_an",   32'(an),   32'b1110);
      chk("t1_seg",  32'(seg),  32'(S0));
      chk("t1_dp",   32'(dp),   32'd1);
      rst = 1'b1;
      check_scan("t1_hold", S0, SB, SB);

      // T2 convert 255, T5 scan
      dataIn = 8'd255;
      @(negedge clk);
      busy_len(n);
      chk("t2_busy_len", 32'(n), 32'd9);
      check_scan("t2_255", S5, S5, S2);

      // T3 blanking
      dataIn = 8'd7;
      @(negedge clk);
      busy_len(n);
      chk("t3_busy_len7", 32'(n), 32'd9);
      check_scan("t3_7", S7, SB, SB);
      dataIn = 8'd40;
      @(negedge clk);
      busy_len(n);
      check_scan("t3_40", S0, S4, SB);
      dataIn = 8'd105;
      @(negedge clk);
      busy_len(n);
      check_scan("t3_105", S5, S0, S1);

      // T4 change during busy: 100, then 42 before E3
      dataIn = 8'd100;
      repeat (3) @(negedge clk);
      chk("t4_busy_e2", 32'(busy), 32'd1);
      dataIn = 8'd42;
      busy_len(n);
      chk("t4_busy_rest", 32'(n), 32'd7);
      check_now("t4_100", S0, S0, S1, SB);
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         chk("t4_busy2", 32'(busy), 32'd1);
         check_now("t4_100_hold", S0, S0, S1, SB);
         @(negedge clk);
      end
      check_scan("t4_42", S2, S4, SB);

      // T6 reset mid-conversion
      dataIn = 8'd200;
      repeat (4) @(negedge clk);
      chk("t6_busy_pre", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      chk("t6_busy_rst", 32'(busy), 32'd0);
      chk("t6_an_rst",   32'(an),   32'b1110);
      chk("t6_seg_rst",  32'(seg),  32'(S0));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         chk("t6_busy_restart", 32'(busy), 32'd1);
         check_now("t6_zero_hold", S0, SB, SB, SB);
         @(negedge clk);
      end
      check_scan("t6_200", S0, S0, S2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
